// File: rtl/mc_control_if.sv
// mc_control_if: instruction/flag inputs and datapath control strobes of the multicycle ARM sequencer
interface mc_control_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        FPUWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic        RegSrc64b;
  logic        Src_64b;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  state_o;
  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite, AdrSrc, RegSrc, RegSrc64b,
           Src_64b, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, state_o
  );
  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite, AdrSrc, RegSrc, RegSrc64b,
           Src_64b, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, state_o
  );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle ARM sequencer with NZCV flags, 32/64-bit multiply and FPU paths
module mc_control_fsm #(
  parameter int FP_EXEC_CYC = 1
) (
  input logic        clk,
  input logic        reset,
  mc_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI,
    ALUWB, BRANCH, EXECM, MULWB, FPEXEC, FPWB
  } state_t;
  localparam logic [3:0] FP_LAST = 4'(FP_EXEC_CYC - 1);
  state_t     state;
  logic [3:0] flags;
  logic [3:0] cnt;
  logic       cond_q;
  logic [1:0] op;
  logic [3:0] cmd;
  logic [3:0] cond;
  logic       s_bit;
  logic       mul;
  logic       dp_ok;
  logic       cmp;
  logic       cex;
  logic [7:0] tbl;
  logic [2:0] alu_cmd;
  logic [2:0] mul_alu;
  assign op      = bus.Instr[27:26];
  assign cmd     = bus.Instr[24:21];
  assign cond    = bus.Instr[31:28];
  assign s_bit   = bus.Instr[20];
  assign mul     = op == 2'b00 && !bus.Instr[25] && bus.Instr[7:4] == 4'b1001;
  assign dp_ok   = cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
  assign cmp     = cmd == 4'b1010;
  assign alu_cmd = cmd == 4'b0100 ? 3'b000 : cmd == 4'b0000 ? 3'b010 : cmd == 4'b1100 ? 3'b011 : 3'b001;
  assign mul_alu = !bus.Instr[23] ? 3'b100 : bus.Instr[22] ? 3'b110 : 3'b101;
  // Even conds test a flag predicate, odd conds its inverse; 111x is always.
  assign tbl = {1'b1, ~flags[2] & (flags[3] == flags[0]), flags[3] == flags[0], flags[1] & ~flags[2],
                flags[0], flags[3], flags[1], flags[2]};
  assign cex = &cond[3:1] | (tbl[cond[3:1]] ^ cond[0]);
  assign bus.state_o = state;
  // Condition is frozen at DECODE so a flag-setting op is judged on the flags it started with.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= FETCH;
      flags  <= '0;
      cnt    <= '0;
      cond_q <= 1'b0;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          cond_q <= cex;
          state  <= op == 2'b01 ? MEMADR : op == 2'b10 ? BRANCH : op == 2'b11 ? FPEXEC :
                    mul ? EXECM : !dp_ok ? FETCH : bus.Instr[25] ? EXECI : EXECR;
        end
        MEMADR: state <= s_bit ? MEMRD : MEMWR;
        MEMRD:  state <= MEMWB;
        EXECR, EXECI, EXECM: begin
          state <= state == EXECM ? MULWB : ALUWB;
          if ((s_bit | (cmp & !mul)) & cond_q) flags <= bus.ALUFlags;
        end
        FPEXEC: begin
          cnt   <= cnt == FP_LAST ? 4'd0 : cnt + 4'd1;
          state <= cnt == FP_LAST ? FPWB : FPEXEC;
        end
        default: state <= FETCH;
      endcase
    end
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.FPUWrite   = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.RegSrc     = 2'b00;
    bus.RegSrc64b  = 1'b0;
    bus.Src_64b    = 1'b0;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ImmSrc     = 2'b00;
    bus.ALUControl = 3'b000;
    case (state)
      FETCH: begin
        bus.IRWrite   = !reset;
        bus.PCWrite   = !reset;
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.RegSrc64b = mul;
      end
      MEMADR: begin
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = 2'b01;
      end
      MEMRD: bus.AdrSrc = 1'b1;
      MEMWR: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = cond_q;
        bus.RegSrc   = 2'b10;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = cond_q;
      end
      EXECR: bus.ALUControl = alu_cmd;
      EXECI: begin
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_cmd;
      end
      ALUWB: begin
        bus.RegWrite = cond_q & !cmp;
        bus.PCWrite  = cond_q & !cmp & (bus.Instr[15:12] == 4'hF);
      end
      BRANCH: begin
        bus.RegSrc    = 2'b01;
        bus.ALUSrcB   = 2'b01;
        bus.ImmSrc    = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = cond_q;
      end
      EXECM: begin
        bus.ALUControl = mul_alu;
        bus.RegSrc64b  = 1'b1;
      end
      MULWB: begin
        bus.RegWrite  = cond_q;
        bus.Src_64b   = bus.Instr[23];
        bus.RegSrc64b = 1'b1;
      end
      FPWB: bus.FPUWrite = cond_q;
      default: ;
    endcase
  end
endmodule
